// File: rtl/hmmm_pkg.sv
// Shared types and widths for the hmmm program loader.
package hmmm_pkg;

    localparam int HMMM_WORD_W = 16;
    localparam int HMMM_ADDR_W = 8;

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR,
        S_HI,
        S_LO,
        S_WADDR,
        S_WDATA,
        S_CSUM,
        S_BOOT,
        S_RUN,
        S_ERR
    } loader_state_t;

endpackage

// File: rtl/hmmm_byte_assembler.sv
// Captures hi/lo stream bytes into a 16-bit word and keeps the running XOR
// checksum over the count byte and all payload bytes.
module hmmm_byte_assembler
    import hmmm_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_clr,
    input  logic                   i_ld_hdr,
    input  logic                   i_ld_hi,
    input  logic                   i_ld_lo,
    input  logic [7:0]             i_byte,
    output logic [HMMM_WORD_W-1:0] o_word,
    output logic [7:0]             o_csum
);

    logic [7:0] r_hi;
    logic [7:0] r_lo;
    logic [7:0] r_csum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi   <= 8'h00;
            r_lo   <= 8'h00;
            r_csum <= 8'h00;
        end else if (i_clr) begin
            r_hi   <= 8'h00;
            r_lo   <= 8'h00;
            r_csum <= 8'h00;
        end else begin
            // The count byte seeds the checksum; payload bytes fold in.
            if (i_ld_hdr) r_csum <= i_byte;
            if (i_ld_hi) begin
                r_hi   <= i_byte;
                r_csum <= r_csum ^ i_byte;
            end
            if (i_ld_lo) begin
                r_lo   <= i_byte;
                r_csum <= r_csum ^ i_byte;
            end
        end
    end

    assign o_word = {r_hi, r_lo};
    assign o_csum = r_csum;

endmodule

// File: rtl/hmmm_loader.sv
// Program-load front end for the hmmm core: parses a counted, checksummed
// byte stream, replays words as addr/data strobe pairs, then boots the core.
module hmmm_loader
    import hmmm_pkg::*;
#(
    parameter int MAX_WORDS  = 255,
    parameter int RST_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    input  logic [15:0] run_in,
    output logic        core_rst,
    output logic        pgrm_addr,
    output logic        pgrm_data,
    output logic [15:0] core_in,
    output logic        loading,
    output logic        done,
    output logic        err
);

    localparam int              BW        = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [7:0]      MAX_N     = 8'(MAX_WORDS);
    localparam logic [BW-1:0]   BOOT_LAST = BW'(RST_CYCLES - 1);

    loader_state_t           r_state;
    loader_state_t           w_next;
    logic [HMMM_ADDR_W-1:0]  r_count;
    logic [HMMM_ADDR_W-1:0]  r_addr;
    logic [BW-1:0]           r_boot;

    logic                    r_byte_ready;
    logic                    r_core_rst;
    logic                    r_pgrm_addr;
    logic                    r_pgrm_data;
    logic [HMMM_WORD_W-1:0]  r_core_in;
    logic                    r_loading;
    logic                    r_done;
    logic                    r_err;

    logic                    w_xfer;
    logic [HMMM_WORD_W-1:0]  w_word;
    logic [7:0]              w_csum;

    assign w_xfer = byte_valid & r_byte_ready;

    hmmm_byte_assembler u_asm (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    ((w_next == S_HDR) && (r_state != S_HDR)),
        .i_ld_hdr ((r_state == S_HDR) && w_xfer),
        .i_ld_hi  ((r_state == S_HI) && w_xfer),
        .i_ld_lo  ((r_state == S_LO) && w_xfer),
        .i_byte   (byte_in),
        .o_word   (w_word),
        .o_csum   (w_csum)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_RUN, S_ERR: if (start) w_next = S_HDR;
            S_HDR:   if (w_xfer) w_next = (byte_in == 8'h00 || byte_in > MAX_N) ? S_ERR : S_HI;
            S_HI:    if (w_xfer) w_next = S_LO;
            S_LO:    if (w_xfer) w_next = S_WADDR;
            S_WADDR: w_next = S_WDATA;
            S_WDATA: w_next = (r_addr == 8'(r_count - 8'd1)) ? S_CSUM : S_HI;
            S_CSUM:  if (w_xfer) w_next = (byte_in == w_csum) ? S_BOOT : S_ERR;
            S_BOOT:  if (r_boot == BOOT_LAST) w_next = S_RUN;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_count      <= '0;
            r_addr       <= '0;
            r_boot       <= '0;
            r_byte_ready <= 1'b0;
            r_core_rst   <= 1'b1;
            r_pgrm_addr  <= 1'b0;
            r_pgrm_data  <= 1'b0;
            r_core_in    <= '0;
            r_loading    <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_HDR && w_xfer) begin
                r_count <= byte_in;
                r_addr  <= '0;
            end
            if (r_state == S_WDATA && w_next == S_HI) r_addr <= r_addr + 8'd1;
            r_boot <= (r_state == S_BOOT) ? BW'(r_boot + 1'b1) : '0;

            r_byte_ready <= w_next inside {S_HDR, S_HI, S_LO, S_CSUM};
            r_loading    <= w_next inside {S_HDR, S_HI, S_LO, S_WADDR, S_WDATA, S_CSUM};
            r_core_rst   <= w_next inside {S_IDLE, S_BOOT, S_ERR};
            r_pgrm_addr  <= (w_next == S_WADDR);
            r_pgrm_data  <= (w_next == S_WDATA);
            r_done       <= (w_next == S_RUN);
            r_err        <= (w_next == S_ERR);
            case (w_next)
                S_WADDR: r_core_in <= {8'h00, r_addr};
                S_WDATA: r_core_in <= w_word;
                S_RUN:   r_core_in <= run_in;
                default: r_core_in <= '0;
            endcase
        end
    end

    assign byte_ready = r_byte_ready;
    assign core_rst   = r_core_rst;
    assign pgrm_addr  = r_pgrm_addr;
    assign pgrm_data  = r_pgrm_data;
    assign core_in    = r_core_in;
    assign loading    = r_loading;
    assign done       = r_done;
    assign err        = r_err;

endmodule

// File: tb/tb_hmmm_loader.sv
// Directed bench for hmmm_loader: frame-level scoreboard of expected strobes
// plus per-cycle protocol checks and hand-computed scenario expectations.
module tb_hmmm_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic [15:0] run_in = 16'h1234;
    logic        byte_ready, core_rst, pgrm_addr, pgrm_data, loading, done, err;
    logic [15:0] core_in;
    logic        d4_byte_ready, d4_core_rst, d4_pgrm_addr, d4_pgrm_data, d4_loading, d4_done, d4_err;
    logic [15:0] d4_core_in;

    int n_pass = 0;
    int n_total = 0;
    int n_xfer = 0;
    logic [7:0]  exp_a[$];
    logic [15:0] exp_d[$];

    always #5 clk = ~clk;

    hmmm_loader #(.MAX_WORDS(255), .RST_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .run_in(run_in),
        .core_rst(core_rst), .pgrm_addr(pgrm_addr), .pgrm_data(pgrm_data),
        .core_in(core_in), .loading(loading), .done(done), .err(err)
    );

    hmmm_loader #(.MAX_WORDS(4), .RST_CYCLES(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(d4_byte_ready), .run_in(run_in),
        .core_rst(d4_core_rst), .pgrm_addr(d4_pgrm_addr), .pgrm_data(d4_pgrm_data),
        .core_in(d4_core_in), .loading(d4_loading), .done(d4_done), .err(d4_err)
    );

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endfunction

    function automatic logic [7:0] frame_csum(input logic [7:0] n, input logic [15:0] w0, input logic [15:0] w1);
        logic [7:0] x;
        logic [15:0] w [2];
        w[0] = w0;
        w[1] = w1;
        x = n;
        for (int i = 0; i < int'(n) && i < 2; i++) x = x ^ w[i][15:8] ^ w[i][7:0];
        return x;
    endfunction

    // Strobe scoreboard and per-cycle protocol rules.
    initial begin
        logic prev_addr, prev_data;
        logic [15:0] prev_run;
        prev_addr = 1'b0;
        prev_data = 1'b0;
        prev_run  = 16'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_addr = 1'b0;
                prev_data = 1'b0;
            end else begin
                if (pgrm_addr && pgrm_data) chk("strobe_overlap", 32'(pgrm_addr & pgrm_data), 0);
                if (prev_addr) chk("data_after_addr", 32'(pgrm_data), 1);
                if (prev_data) chk("ready_after_data", 32'(byte_ready), 1);
                if (pgrm_addr) begin
                    chk("addr_expected", 32'(exp_a.size() > 0), 1);
                    if (exp_a.size() > 0) chk("addr_value", 32'(core_in), {24'h0, exp_a[0]});
                end
                if (pgrm_data) begin
                    chk("data_expected", 32'(exp_d.size() > 0), 1);
                    if (exp_d.size() > 0) begin
                        chk("data_value", 32'(core_in), {16'h0, exp_d[0]});
                        void'(exp_a.pop_front());
                        void'(exp_d.pop_front());
                    end
                end
                if (done) chk("run_passthru", 32'(core_in), {16'h0, prev_run});
                if (byte_valid && byte_ready) n_xfer++;
                prev_addr = pgrm_addr;
                prev_data = pgrm_data;
            end
            prev_run = run_in;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int k;
        byte_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        byte_in = b;
        byte_valid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!byte_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) chk("byte_accept", 32'(byte_ready), 1);
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic load_frame(input logic [7:0] n, input logic [15:0] w0, input logic [15:0] w1,
                              input logic [7:0] cs, input int gap);
        logic [15:0] w [2];
        w[0] = w0;
        w[1] = w1;
        send_byte(n, gap);
        for (int i = 0; i < int'(n); i++) begin
            send_byte(w[i][15:8], gap);
            exp_a.push_back(8'(i));
            exp_d.push_back(w[i]);
            send_byte(w[i][7:0], gap);
        end
        send_byte(cs, gap);
    endtask

    task automatic start_pulse();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic boot_check();
        int c;
        c = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) break;
            if (core_rst) c++;
        end
        chk("boot_cycles", 32'(c), 2);
        chk("run_done", 32'(done), 1);
        chk("run_core_rst", 32'(core_rst), 0);
        chk("queue_drained", 32'(exp_a.size()), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_core_rst"}, 32'(core_rst), 1);
        chk({tag, "_ready"}, 32'(byte_ready), 0);
        chk({tag, "_strobes"}, 32'({pgrm_addr, pgrm_data}), 0);
        chk({tag, "_core_in"}, 32'(core_in), 0);
        chk({tag, "_flags"}, 32'({loading, done, err}), 0);
    endtask

    initial begin
        int x0;
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int x0;
        #12;
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_core_rst", 32'(core_rst), 1);
        chk("idle_loading", 32'(loading), 0);

        chk("model_csum_f1", 32'(frame_csum(8'h02, 16'h1F64, 16'h0101)), 32'h79);
        chk("model_csum_f6", 32'(frame_csum(8'h01, 16'h0000, 16'h0000)), 32'h01);

        // 1: good load, next word presented during WADDR/WDATA
        x0 = n_xfer;
        start_pulse();
        @(negedge clk);
        chk("hdr_flags", 32'({loading, byte_ready, core_rst}), 32'b110);
        @(posedge clk);
        #1;
        load_frame(8'h02, 16'h1F64, 16'h0101, 8'h79, 0);
        boot_check();
        chk("s1_xfers", 32'(n_xfer - x0), 6);
        run_in = 16'd42;
        @(posedge clk);
        @(negedge clk);
        chk("run_in_42", 32'(core_in), 42);
        @(posedge clk);
        #1;

        // 2: bad checksum, then recovery
        start_pulse();
        load_frame(8'h02, 16'h1F64, 16'h0101, 8'h78, 0);
        @(negedge clk);
        chk("bad_cs_flags", 32'({err, core_rst, byte_ready, done}), 32'b1100);
        chk("bad_cs_queue", 32'(exp_a.size()), 0);
        @(posedge clk);
        #1;
        start_pulse();
        load_frame(8'h02, 16'h1F64, 16'h0101, 8'h79, 0);
        boot_check();

        // 3: count framing errors
        start_pulse();
        send_byte(8'h00, 0);
        @(negedge clk);
        chk("cnt0_err", 32'({err, core_rst, loading}), 32'b110);
        @(posedge clk);
        #1;
        start_pulse();
        send_byte(8'h05, 0);
        @(negedge clk);
        chk("cnt5_max4_err", 32'(d4_err), 1);
        chk("cnt5_max255_loading", 32'({err, loading}), 32'b01);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 4: 3-cycle gaps before every byte
        x0 = n_xfer;
        start_pulse();
        load_frame(8'h02, 16'h1F64, 16'h0101, 8'h79, 3);
        boot_check();
        chk("s4_xfers", 32'(n_xfer - x0), 6);

        // 5: asynchronous reset after the hi byte of word 1
        start_pulse();
        send_byte(8'h02, 0);
        send_byte(8'h1F, 0);
        exp_a.push_back(8'h00);
        exp_d.push_back(16'h1F64);
        send_byte(8'h64, 0);
        send_byte(8'h01, 0);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        exp_a.delete();
        exp_d.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        start_pulse();
        load_frame(8'h02, 16'h1F64, 16'h0101, 8'h79, 0);
        boot_check();

        // 6: reload straight from RUN with a 1-word frame
        start_pulse();
        @(negedge clk);
        chk("reload_flags", 32'({done, core_rst, byte_ready}), 32'b001);
        @(posedge clk);
        #1;
        load_frame(8'h01, 16'h0000, 16'h0000, 8'h01, 0);
        boot_check();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hmmm_loader.md
Name: hmmm_loader

Overview:
Program-load front end that sits directly upstream of the hmmm core. It receives a byte stream (count, payload words, checksum), assembles 16-bit instruction words, and replays them into the core's program-write port as address/data strobe pairs on the core's 16-bit input bus. After a good checksum it pulses core reset and hands the input bus over to run-time data. The same single clock drives both the loader and the core.

Parameters:
MAX_WORDS, 255, largest accepted word count (1..255); a larger count byte is a framing error
RST_CYCLES, 2, number of cycles core_rst is held high in BOOT (>=1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin a load; honoured in IDLE, RUN, ERR; ignored otherwise
byte_in  input  8  stream byte
byte_valid  input  1  byte_in valid
byte_ready  output  1  loader accepts byte this cycle; transfer = byte_valid & byte_ready
run_in  input  16  run-time data passed to core in RUN
core_rst  output  1  to core rst, active-high
pgrm_addr  output  1  to core pgrm_addr strobe
pgrm_data  output  1  to core pgrm_data strobe
core_in  output  16  to core in bus
loading  output  1  high in HDR..CSUM
done  output  1  high in RUN
err  output  1  high in ERR

Behaviour:
- Reset (rst_n low, async): state IDLE; core_rst=1; pgrm_addr=pgrm_data=0; core_in=0; byte_ready=0; loading=done=err=0; word counter, address, checksum and boot counter cleared.
- All outputs registered; outputs below are per state.
- Frame: count byte N, then N words big-endian (hi byte, lo byte), then checksum byte = XOR of count byte and all 2N payload bytes.
- States:
  - IDLE: core_rst=1, core_in=0; start -> HDR.
  - HDR: core_rst=0, byte_ready=1. On transfer, csum<=byte. N==0 or N>MAX_WORDS -> ERR; else latch N, addr<=0 -> HI.
  - HI: byte_ready=1; on transfer latch hi byte, fold into csum -> LO.
  - LO: byte_ready=1; on transfer latch lo byte, fold into csum -> WADDR.
  - WADDR (1 cycle): pgrm_addr=1, core_in={8'h00,addr}, byte_ready=0 -> WDATA.
  - WDATA (1 cycle): pgrm_data=1, core_in=assembled word. If addr==N-1 -> CSUM; else addr<=addr+1 -> HI.
  - CSUM: byte_ready=1; on transfer, byte==csum -> BOOT (boot counter<=0); else -> ERR.
  - BOOT: core_rst=1 for exactly RST_CYCLES cycles, core_in=0 -> RUN.
  - RUN: core_rst=0, done=1, core_in=run_in (registered, 1-cycle latency); start -> HDR.
  - ERR: err=1, core_rst=1, core_in=0, byte_ready=0; start -> HDR.
- Strobe timing: LO byte accepted at edge t -> pgrm_addr high in cycle t+1, pgrm_data high in cycle t+2, byte_ready high again in cycle t+3. pgrm_addr and pgrm_data are never high together. Each strobe lasts exactly 1 cycle.
- byte_valid gaps: the loader waits indefinitely in HDR/HI/LO/CSUM. There is no timeout.
- start while loading, or in BOOT, is ignored. A start arriving in the same cycle as a transfer in RUN/IDLE/ERR is irrelevant, since byte_ready=0 there.
- Asynchronous reset mid-load aborts the load. core_rst rises immediately and the partial program is not re-sent.
- Address width is 8 bits with no wrap, because N<=255.

Decomposition:
- Shared package hmmm_pkg: loader state encoding, HMMM_WORD_W=16, HMMM_ADDR_W=8.
- One natural sub-module: hmmm_byte_assembler (hi/lo byte capture, running XOR checksum, clear on HDR entry).
- The FSM and boot counter stay in hmmm_loader.

Test Plan:
1. Good load: start; bytes 02,1F,64,01,01,79 -> pgrm_addr with core_in=0x0000, then pgrm_data with 0x1F64; pgrm_addr with 0x0001, then pgrm_data with 0x0101; core_rst high 2 cycles; then done=1; run_in=42 gives core_in=42 one cycle later.
2. Bad checksum: same frame with last byte 78 -> err=1, core_rst=1, byte_ready=0, done=0; then start and a good frame -> RUN.
3. Count framing: count byte 00 -> ERR after 1 byte, no strobes. With MAX_WORDS=4, count byte 05 -> ERR.
4. Backpressure/gaps: same frame as scenario 1 with byte_valid low for 3 random cycles between every byte -> identical strobe sequence, and no byte accepted while byte_ready=0 (in WADDR/WDATA).
5. Reset mid-load: assert rst_n low after the hi byte of word 1 -> all outputs at reset values asynchronously, core_rst=1, state IDLE; start plus a full frame then loads correctly.
6. Reload from RUN: start in RUN -> done=0, core_rst=0, byte_ready=1; a 1-word frame 01,00,00,01 (word 0x0000, checksum 0x01) -> strobes addr 0/data 0x0000, then BOOT and RUN.
